// File: rtl/act_collect_argmax_pkg.sv
// Shared types and constants for the activation collector / arg-max stage.
package act_collect_argmax_pkg;

    localparam int unsigned ACC_W_DEF = 32;
    localparam int unsigned OUT_W_DEF = 32;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        STREAM  = 1'b1
    } state_e;

    // Largest value representable in w unsigned bits, widened to 64 bits.
    function automatic logic [63:0] sat_max(input int unsigned w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

endpackage

// File: rtl/act_collect_argmax_relu_quant.sv
// Combinational ReLU, right-shift requantisation and unsigned saturation.
module relu_quant
    import act_collect_argmax_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned OUT_W = OUT_W_DEF,
    parameter int unsigned SHIFT = 8
) (
    input  logic signed [ACC_W-1:0] a,
    output logic        [ACC_W-1:0] r_c,
    output logic        [OUT_W-1:0] y_c
);

    localparam logic [63:0] SAT_MAX = sat_max(OUT_W);

    logic [ACC_W-1:0] q;

    always_comb begin
        r_c = a[ACC_W-1] ? '0 : $unsigned(a);
        q   = r_c >> SHIFT;
        y_c = (64'(q) > SAT_MAX) ? OUT_W'(SAT_MAX) : OUT_W'(q);
    end

endmodule

// File: rtl/act_collect_argmax.sv
// Collects one accumulator result per neuron, tracks the arg-max and streams
// the quantised activations downstream once the layer is complete.
module act_collect_argmax
    import act_collect_argmax_pkg::*;
#(
    parameter int unsigned N_NEURONS = 10,
    parameter int unsigned ACC_W     = ACC_W_DEF,
    parameter int unsigned OUT_W     = OUT_W_DEF,
    parameter int unsigned SHIFT     = 8,
    parameter int unsigned IDX_W     = $clog2(N_NEURONS)
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_areset,
    input  logic signed [ACC_W-1:0] a_tdata,
    input  logic                    a_tvalid,
    output logic                    a_tready,
    output logic        [OUT_W-1:0] y_tdata,
    output logic                    y_tvalid,
    input  logic                    y_tready,
    output logic                    y_tlast,
    output logic        [IDX_W-1:0] class_idx,
    output logic                    class_valid,
    output logic                    frame_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [IDX_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [ACC_W-1:0]   max_r_q, max_r_d;
    logic [IDX_W-1:0]   max_idx_q, max_idx_d;
    logic               max_valid_q, max_valid_d;
    logic [OUT_W-1:0]   buf_q [N_NEURONS];
    logic [OUT_W-1:0]   buf_d [N_NEURONS];
    logic               a_tready_q, a_tready_d;
    logic [OUT_W-1:0]   y_tdata_q, y_tdata_d;
    logic               y_tvalid_q, y_tvalid_d;
    logic               y_tlast_q, y_tlast_d;
    logic [IDX_W-1:0]   class_idx_q, class_idx_d;
    logic               class_valid_q, class_valid_d;
    logic               frame_done_q, frame_done_d;

    logic [ACC_W-1:0]   r_c;
    logic [OUT_W-1:0]   y_c;
    logic               a_acc_c;
    logic               y_acc_c;

    relu_quant #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_relu_quant (
        .a   (a_tdata),
        .r_c (r_c),
        .y_c (y_c)
    );

    assign a_acc_c = a_tvalid && a_tready_q;
    assign y_acc_c = y_tvalid_q && y_tready;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d       = state_q;
        wr_cnt_d      = wr_cnt_q;
        rd_cnt_d      = rd_cnt_q;
        max_r_d       = max_r_q;
        max_idx_d     = max_idx_q;
        max_valid_d   = max_valid_q;
        buf_d         = buf_q;
        a_tready_d    = a_tready_q;
        y_tdata_d     = y_tdata_q;
        y_tvalid_d    = y_tvalid_q;
        y_tlast_d     = y_tlast_q;
        class_idx_d   = class_idx_q;
        class_valid_d = class_valid_q;
        frame_done_d  = 1'b0;

        case (state_q)
            COLLECT: begin
                if (a_acc_c) begin
                    buf_d[wr_cnt_q] = y_c;
                    // Strict compare so ties keep the lowest index.
                    if (!max_valid_q || (r_c > max_r_q)) begin
                        max_r_d   = r_c;
                        max_idx_d = wr_cnt_q;
                    end
                    max_valid_d = 1'b1;
                    if (wr_cnt_q == LAST_IDX) begin
                        wr_cnt_d      = '0;
                        rd_cnt_d      = '0;
                        state_d       = STREAM;
                        class_idx_d   = max_idx_d;
                        class_valid_d = 1'b1;
                        a_tready_d    = 1'b0;
                        y_tvalid_d    = 1'b1;
                        y_tdata_d     = buf_q[0];
                        y_tlast_d     = 1'b0;
                    end else begin
                        wr_cnt_d = wr_cnt_q + IDX_W'(1);
                    end
                end
            end
            STREAM: begin
                if (y_acc_c) begin
                    if (rd_cnt_q == LAST_IDX) begin
                        rd_cnt_d     = '0;
                        max_valid_d  = 1'b0;
                        state_d      = COLLECT;
                        frame_done_d = 1'b1;
                        a_tready_d   = 1'b1;
                        y_tvalid_d   = 1'b0;
                        y_tlast_d    = 1'b0;
                    end else begin
                        rd_cnt_d  = rd_cnt_q + IDX_W'(1);
                        y_tdata_d = buf_q[rd_cnt_d];
                        y_tlast_d = (rd_cnt_d == LAST_IDX);
                    end
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // Ready mirrors COLLECT, so it comes out of reset asserted.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            state_q       <= COLLECT;
            wr_cnt_q      <= '0;
            rd_cnt_q      <= '0;
            max_r_q       <= '0;
            max_idx_q     <= '0;
            max_valid_q   <= 1'b0;
            a_tready_q    <= 1'b1;
            y_tdata_q     <= '0;
            y_tvalid_q    <= 1'b0;
            y_tlast_q     <= 1'b0;
            class_idx_q   <= '0;
            class_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_cnt_q      <= wr_cnt_d;
            rd_cnt_q      <= rd_cnt_d;
            max_r_q       <= max_r_d;
            max_idx_q     <= max_idx_d;
            max_valid_q   <= max_valid_d;
            a_tready_q    <= a_tready_d;
            y_tdata_q     <= y_tdata_d;
            y_tvalid_q    <= y_tvalid_d;
            y_tlast_q     <= y_tlast_d;
            class_idx_q   <= class_idx_d;
            class_valid_q <= class_valid_d;
            frame_done_q  <= frame_done_d;
        end
    end

    // Activation buffer carries no reset; stale contents are never read.
    always_ff @(posedge s_axi_aclk) begin
        buf_q <= buf_d;
    end

    assign a_tready    = a_tready_q;
    assign y_tdata     = y_tdata_q;
    assign y_tvalid    = y_tvalid_q;
    assign y_tlast     = y_tlast_q;
    assign class_idx   = class_idx_q;
    assign class_valid = class_valid_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_act_collect_argmax.sv
// Directed bench with a beat scoreboard for act_collect_argmax.
module tb_act_collect_argmax;

    localparam int N = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default instance: OUT_W=32, SHIFT=8
    logic signed [31:0] a_tdata;
    logic               a_tvalid, a_tready;
    logic        [31:0] y_tdata;
    logic               y_tvalid, y_tready, y_tlast;
    logic        [3:0]  class_idx;
    logic               class_valid, frame_done;

    // Saturation instance: OUT_W=16, SHIFT=0
    logic signed [31:0] b_a_tdata;
    logic               b_a_tvalid, b_a_tready;
    logic        [15:0] b_y_tdata;
    logic               b_y_tvalid, b_y_tready, b_y_tlast;
    logic        [3:0]  b_class_idx;
    logic               b_class_valid, b_frame_done;

    act_collect_argmax #(.N_NEURONS(N), .ACC_W(32), .OUT_W(32), .SHIFT(8)) u_dut (
        .s_axi_aclk(clk), .s_axi_areset(rst),
        .a_tdata(a_tdata), .a_tvalid(a_tvalid), .a_tready(a_tready),
        .y_tdata(y_tdata), .y_tvalid(y_tvalid), .y_tready(y_tready), .y_tlast(y_tlast),
        .class_idx(class_idx), .class_valid(class_valid), .frame_done(frame_done)
    );

    act_collect_argmax #(.N_NEURONS(N), .ACC_W(32), .OUT_W(16), .SHIFT(0)) u_dut_sat (
        .s_axi_aclk(clk), .s_axi_areset(rst),
        .a_tdata(b_a_tdata), .a_tvalid(b_a_tvalid), .a_tready(b_a_tready),
        .y_tdata(b_y_tdata), .y_tvalid(b_y_tvalid), .y_tready(b_y_tready), .y_tlast(b_y_tlast),
        .class_idx(b_class_idx), .class_valid(b_class_valid), .frame_done(b_frame_done)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t exp_a[$];
    beat_t exp_b[$];
    logic  rand_rdy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qmodel(input logic signed [31:0] a, input int sh, input int ow);
        logic [31:0] r;
        logic [31:0] q;
        logic [63:0] mx;
        r  = (a < 0) ? 32'd0 : 32'(a);
        q  = r >> sh;
        mx = (64'd1 << ow) - 64'd1;
        return (64'(q) > mx) ? mx[31:0] : q;
    endfunction

    function automatic int argmax(input logic signed [31:0] v[N]);
        longint best = -1;
        longint r;
        int     idx  = 0;
        for (int i = 0; i < N; i++) begin
            r = (v[i] < 0) ? 64'sd0 : longint'(v[i]);
            if (r > best) begin
                best = r;
                idx  = i;
            end
        end
        return idx;
    endfunction

    // Scoreboard/monitor for the default instance.
    logic        fd_exp     = 1'b0;
    logic        stall_prev = 1'b0;
    logic [31:0] held_data;
    logic        held_last;
    always @(negedge clk) begin
        if (rst) begin
            exp_a.delete();
            fd_exp     = 1'b0;
            stall_prev = 1'b0;
        end else begin
            beat_t b;
            chk("frame_done", 32'(frame_done), 32'(fd_exp));
            fd_exp = 1'b0;
            if (y_tvalid) chk("a_tready_in_stream", 32'(a_tready), 32'd0);
            if (stall_prev) begin
                chk("stall_valid", 32'(y_tvalid), 32'd1);
                chk("stall_data", y_tdata, held_data);
                chk("stall_last", 32'(y_tlast), 32'(held_last));
            end
            stall_prev = y_tvalid && !y_tready;
            held_data  = y_tdata;
            held_last  = y_tlast;
            if (y_tvalid && y_tready) begin
                if (exp_a.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_beat: observed data %0h expected none", y_tdata);
                end else begin
                    b = exp_a.pop_front();
                    chk("y_tdata", y_tdata, b.data);
                    chk("y_tlast", 32'(y_tlast), 32'(b.last));
                    if (b.last) fd_exp = 1'b1;
                end
            end
        end
    end

    // Scoreboard/monitor for the saturation instance.
    always @(negedge clk) begin
        if (rst) begin
            exp_b.delete();
        end else if (b_y_tvalid && b_y_tready) begin
            beat_t b;
            if (exp_b.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sat_unexpected_beat: observed data %0h expected none", b_y_tdata);
            end else begin
                b = exp_b.pop_front();
                chk("sat_y_tdata", 32'(b_y_tdata), b.data);
                chk("sat_y_tlast", 32'(b_y_tlast), 32'(b.last));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) y_tready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic send(input bit sel, input logic signed [31:0] v);
        int n = 0;
        if (sel) begin
            b_a_tdata  = v;
            b_a_tvalid = 1'b1;
        end else begin
            a_tdata  = v;
            a_tvalid = 1'b1;
        end
        while (!(sel ? b_a_tready : a_tready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $error("FAIL send_timeout: observed ready low for %0d cycles expected high", n);
        end else if (!sel && n > 0) begin
            chk("accept_after_last_beat", 32'(frame_done), 32'd1);
        end
        @(negedge clk);
    endtask

    task automatic frame(input bit sel, input logic signed [31:0] v[N], input int sh,
                         input int ow, input bit keep_valid, input int prev_cls);
        beat_t b;
        for (int i = 0; i < N; i++) begin
            b.data = qmodel(v[i], sh, ow);
            b.last = (i == N - 1);
            if (sel) exp_b.push_back(b);
            else     exp_a.push_back(b);
        end
        for (int i = 0; i < N; i++) begin
            send(sel, v[i]);
            if (prev_cls >= 0 && i < N - 1) chk("class_idx_held", 32'(class_idx), 32'(prev_cls));
        end
        if (!keep_valid) begin
            if (sel) b_a_tvalid = 1'b0;
            else     a_tvalid   = 1'b0;
        end
        if (sel) begin
            chk("sat_first_valid", 32'(b_y_tvalid), 32'd1);
            chk("sat_class_valid", 32'(b_class_valid), 32'd1);
            chk("sat_class_idx", 32'(b_class_idx), 32'(argmax(v)));
        end else begin
            chk("first_valid", 32'(y_tvalid), 32'd1);
            chk("class_valid", 32'(class_valid), 32'd1);
            chk("class_idx", 32'(class_idx), 32'(argmax(v)));
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $error("FAIL drain_timeout: observed %0d beats pending expected 0", exp_a.size() + exp_b.size());
        end
        @(negedge clk);
    endtask

    initial begin
        logic signed [31:0] v[N];

        a_tdata    = '0;
        a_tvalid   = 1'b0;
        y_tready   = 1'b1;
        b_a_tdata  = '0;
        b_a_tvalid = 1'b0;
        b_y_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_y_tvalid", 32'(y_tvalid), 32'd0);
        chk("rst_y_tdata", y_tdata, 32'd0);
        chk("rst_y_tlast", 32'(y_tlast), 32'd0);
        chk("rst_class_valid", 32'(class_valid), 32'd0);
        chk("rst_class_idx", 32'(class_idx), 32'd0);
        chk("rst_a_tready", 32'(a_tready), 32'd1);
        chk("rst_sat_a_tready", 32'(b_a_tready), 32'd1);

        // Ramp 256*k -> activations 0..9, class 9
        for (int i = 0; i < N; i++) v[i] = 32'(256 * i);
        frame(1'b0, v, 8, 32, 1'b0, -1);
        drain();

        // Negative and saturating inputs on the 16-bit instance
        v = '{-500, 32'sh7FFFFFFF, 5, 7, 100, 65535, 65536, 3, 2, 1};
        frame(1'b1, v, 0, 16, 1'b0, -1);
        drain();
        // Ties at indices 3 and 6 keep the lower index
        v = '{10, 20, 30, 1000, 40, 50, 1000, 60, 70, 80};
        frame(1'b1, v, 0, 16, 1'b0, -1);
        drain();

        // All-negative frame
        for (int i = 0; i < N; i++) v[i] = -32'sd1000 * (i + 1);
        frame(1'b0, v, 8, 32, 1'b0, -1);
        drain();
        chk("neg_class_valid_hold", 32'(class_valid), 32'd1);

        // Random backpressure with a_tvalid held into the next frame
        rand_rdy = 1'b1;
        for (int i = 0; i < N; i++) v[i] = $signed($urandom());
        frame(1'b0, v, 8, 32, 1'b1, -1);
        for (int i = 0; i < N; i++) v[i] = $signed($urandom());
        frame(1'b0, v, 8, 32, 1'b0, -1);
        drain();
        rand_rdy = 1'b0;
        @(posedge clk);
        #1 y_tready = 1'b1;
        @(negedge clk);

        // Reset after the fourth streamed beat
        for (int i = 0; i < N; i++) v[i] = 32'(300 * (i + 5));
        frame(1'b0, v, 8, 32, 1'b0, -1);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_y_tvalid", 32'(y_tvalid), 32'd0);
        chk("midrst_class_valid", 32'(class_valid), 32'd0);
        chk("midrst_a_tready", 32'(a_tready), 32'd1);
        for (int i = 0; i < N; i++) v[i] = 32'(4096 - 256 * i);
        frame(1'b0, v, 8, 32, 1'b0, -1);
        drain();

        // Back-to-back frames: maximum at index 2, then at index 7
        v = '{100, 200, 9000, 300, 400, -5, 500, 600, 700, 800};
        frame(1'b0, v, 8, 32, 1'b1, -1);
        v = '{50, 60, 70, 80, 90, 100, 110, 12000, 120, 130};
        frame(1'b0, v, 8, 32, 1'b0, 2);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
